// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MULT_CYCLES_DEF = 16;
    localparam int DIV_CYCLES_DEF  = 32;

    // Width that can represent the larger iteration count itself.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/multdiv_step_counter.sv
// rtl/multdiv_step_counter.sv - datapath iteration counter with last-step flag
// Ports: clock, reset (sync, active-high), clear (zero count), enable (increment),
//        limit (iterations for current op), count (current step), last (count == limit-1).
module multdiv_step_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    assign last = (count == (limit - ONE));

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencing FSM for the iterative multiply/divide datapath
// Optional feature macro: MULTDIV_EARLY_TERM_EN (adds early_done input for multiply).
// Ports: clock, reset (sync, active-high); ctrl_MULT / ctrl_DIV start pulses;
//        divisor_zero from datapath during LOAD; load / step_en datapath strobes;
//        op_is_div latched op; busy pipeline stall; data_resultRDY result pulse;
//        data_exception divide-by-zero flag; count current step index.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
`ifdef MULTDIV_EARLY_TERM_EN
    input  logic             early_done,
`endif
    output logic             load,
    output logic             step_en,
    output logic             op_is_div,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    logic             start;
    logic             last;
    logic             early_stop;
    logic             finish;
    logic [CNT_W-1:0] limit;

    assign start = ctrl_MULT | ctrl_DIV;
    assign limit = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

`ifdef MULTDIV_EARLY_TERM_EN
    assign early_stop = early_done & ~op_is_div;
`else
    assign early_stop = 1'b0;
`endif

    assign finish = last | early_stop;

    // Clearing on the start edge puts count at 0 already during LOAD; the
    // counter freezes on the final step so count holds its last index.
    multdiv_step_counter #(
        .CNT_W(CNT_W)
    ) u_step_counter (
        .clock (clock),
        .reset (reset),
        .clear (start),
        .enable((state == RUN) && !finish),
        .limit (limit),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            load           <= 1'b0;
            step_en        <= 1'b0;
            op_is_div      <= 1'b0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            load           <= 1'b0;
            step_en        <= 1'b0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            if (start) begin
                // Start from any state, aborting whatever was in flight.
                // Multiply has priority when both pulses arrive together.
                state     <= LOAD;
                op_is_div <= ctrl_DIV & ~ctrl_MULT;
                load      <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        if (op_is_div && divisor_zero) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            data_exception <= 1'b1;
                            busy           <= 1'b0;
                        end else begin
                            state   <= RUN;
                            step_en <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (finish) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                        end else begin
                            step_en <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - scoreboard bench for multdiv_ctrl
module tb_multdiv_ctrl;

    logic       clock;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       divisor_zero;
`ifdef MULTDIV_EARLY_TERM_EN
    logic       early_done;
`endif
    logic       load;
    logic       step_en;
    logic       op_is_div;
    logic       busy;
    logic       data_resultRDY;
    logic       data_exception;
    logic [5:0] count;

    typedef struct {
        int cyc;
        int exc;
        int div;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;
    int   base2;

    multdiv_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .divisor_zero  (divisor_zero),
`ifdef MULTDIV_EARLY_TERM_EN
        .early_done    (early_done),
`endif
        .load          (load),
        .step_en       (step_en),
        .op_is_div     (op_is_div),
        .busy          (busy),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int outs();
        return int'({load, step_en, op_is_div, busy, data_resultRDY, data_exception, count});
    endfunction

    task automatic push(input int c, input int e, input int d);
        exp_t x;
        x.cyc = c;
        x.exc = e;
        x.div = d;
        sb.push_back(x);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("rdy_cycle", cyc, x.cyc);
                check("rdy_exception", int'(data_exception), x.exc);
                check("rdy_op_is_div", int'(op_is_div), x.div);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b0;
`ifdef MULTDIV_EARLY_TERM_EN
        early_done   = 1'b0;
`endif
        // Reset held 3 cycles, then 10 quiet cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_outs", outs(), 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_outs", outs(), 0);
        end

        // Multiply, with a back-to-back restart issued in the DONE cycle.
        base = cyc;
        ctrl_MULT = 1'b1;
        push(base + 18, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            check("mul_load", int'(load), int'(k == 1));
            check("mul_step_en", int'(step_en), int'(k >= 2 && k <= 17));
            check("mul_busy", int'(busy), int'(k <= 17));
            if (k == 1) check("mul_count_load", int'(count), 0);
            if (k >= 2 && k <= 17) check("mul_count_run", int'(count), k - 2);
            if (k == 18) check("mul_count_done", int'(count), 15);
        end
        base2 = cyc;
        ctrl_MULT = 1'b1;
        push(base2 + 18, 0, 0);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("b2b_load", int'(load), 1);
        idle_cycles(20);

        // Divide by zero: exception result two cycles after start, no steps.
        base = cyc;
        ctrl_DIV = 1'b1;
        divisor_zero = 1'b1;
        push(base + 2, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (k == 2) divisor_zero = 1'b0;
            check("dz_step_en", int'(step_en), 0);
        end
        idle_cycles(3);

        // Divide aborted by a multiply at cycle 10.
        base = cyc;
        ctrl_DIV = 1'b1;
        push(base + 28, 0, 0);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            ctrl_MULT = (k == 10);
            check("abort_busy", int'(busy), int'(k <= 27));
            if (k >= 2 && k <= 10) check("abort_div_latched", int'(op_is_div), 1);
            if (k >= 11) check("abort_op_is_div", int'(op_is_div), 0);
        end
        ctrl_MULT = 1'b0;
        idle_cycles(3);

        // Both pulses together: multiply wins.
        base = cyc;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        push(base + 18, 0, 0);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = 1'b0;
            check("both_op_is_div", int'(op_is_div), 0);
        end
        idle_cycles(2);

        // Reset mid-RUN at count 7: outputs clear, no result for that op.
        base = cyc;
        ctrl_DIV = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
        end
        check("midrun_count", int'(count), 7);
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_outs", outs(), 0);
        reset = 1'b0;
        idle_cycles(40);
        check("midrun_idle_outs", outs(), 0);

        // Reset beats a same-cycle start.
        reset = 1'b1;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        check("reset_vs_start_outs", outs(), 0);
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        @(negedge clock);
        check("reset_vs_start_idle", outs(), 0);
        idle_cycles(20);

`ifdef MULTDIV_EARLY_TERM_EN
        // Early termination on a multiply at count 4.
        base = cyc;
        ctrl_MULT = 1'b1;
        push(base + 7, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            early_done = (k == 6);
            if (k == 6) check("early_count", int'(count), 4);
        end
        early_done = 1'b0;
        idle_cycles(2);

        // Same stimulus on a divide is ignored.
        base = cyc;
        ctrl_DIV = 1'b1;
        push(base + 34, 0, 1);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            early_done = (k == 6);
        end
        early_done = 1'b0;
        idle_cycles(2);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the processor's iterative multiply/divide datapath.
- Accepts one-cycle start pulses from the pipeline, then drives the datapath's load and step-enable strobes.
- Counts datapath iterations with an internal step counter and reports completion and exceptions to the pipeline.
- Drives the pipeline stall while an operation is in flight.

Parameters:
MULT_CYCLES, 16, number of step cycles for a multiply (radix-4 Booth, 32-bit operands)
DIV_CYCLES, 32, number of step cycles for a divide (restoring, one quotient bit per cycle)
CNT_W, 6, step counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high
ctrl_MULT  in  1  start-multiply pulse
ctrl_DIV  in  1  start-divide pulse
divisor_zero  in  1  from datapath; valid during LOAD
load  out  1  datapath operand-register load strobe
step_en  out  1  datapath iteration enable
op_is_div  out  1  latched operation select, 1 = divide
busy  out  1  high in LOAD and RUN; pipeline stall
data_resultRDY  out  1  one-cycle result-valid pulse
data_exception  out  1  qualified by data_resultRDY; divide by zero
count  out  CNT_W  current step index

Behaviour:
- Reset (sync, active-high) forces:
  - state IDLE, all outputs 0, count 0.
  - Reset overrides everything, including an in-flight operation and a same-cycle start pulse.
- FSM states:
  - IDLE: wait for a start pulse.
  - LOAD: load=1, busy=1, count=0.
  - RUN: step_en=1, busy=1.
  - DONE: data_resultRDY=1, busy=0.
- Start:
  - Sampled at the clock edge in any non-reset state.
  - Latches op_is_div (ctrl_DIV=1 -> 1, else 0).
  - Next state is LOAD.
  - If ctrl_MULT and ctrl_DIV are both high, multiply wins (op_is_div=0).
- Restart:
  - A start pulse during LOAD, RUN or DONE aborts the current operation.
  - Restart behaves exactly like a start from IDLE.
  - No data_resultRDY is issued for the aborted operation.
- LOAD -> RUN, except when op_is_div=1 and divisor_zero=1: LOAD -> DONE with data_exception=1.
- RUN:
  - count increments each cycle starting at 0.
  - When count == N-1 (N = MULT_CYCLES or DIV_CYCLES per op_is_div), the next state is DONE.
  - count holds N-1 until the next LOAD.
- DONE -> IDLE after one cycle. data_resultRDY and data_exception are high only in DONE.
- Latency (start sampled at edge 0):
  - LOAD in cycle 1, RUN in cycles 2..N+1, DONE in cycle N+2.
  - Multiply: RDY in cycle 18. Divide: RDY in cycle 34. Divide by zero: RDY in cycle 2.
- Throughput: a new start may be issued in the DONE cycle with no dead cycle.
- Counter: no wrap in legal operation. Defaults fit CNT_W=6.

Optional Feature:
Macro MULTDIV_EARLY_TERM_EN.
- Defined:
  - Adds input early_done (1 bit), asserted by the datapath when the remaining multiplier bits are all zero.
  - In RUN with op_is_div=0, early_done=1 forces the next state to DONE after the current step.
  - Divide ignores early_done.
- Undefined:
  - The port is absent.
  - Multiply always takes exactly MULT_CYCLES steps.

Decomposition:
- Package multdiv_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE), 2-bit encoding.
  - MULT_CYCLES and DIV_CYCLES default constants.
  - CNT_W derivation.
- One sub-module, multdiv_step_counter.
  - Ports: clock, reset, clear, enable, count, last.
  - last is driven when count == limit-1; limit is an input.
- The FSM stays in multdiv_ctrl.

Test Plan:
- Reset held for 3 cycles, then released with no start -> all outputs 0 and state IDLE for 10 cycles.
- ctrl_MULT pulse at cycle 0 -> load=1 in cycle 1; step_en=1 in cycles 2..17 with count 0..15; data_resultRDY=1 in cycle 18 only; data_exception=0.
- ctrl_DIV pulse with divisor_zero=1 in LOAD -> data_resultRDY=1 and data_exception=1 in cycle 2; step_en never asserted.
- ctrl_DIV at cycle 0, then ctrl_MULT at cycle 10 -> DIV aborted with no RDY; op_is_div=0; RDY in cycle 28; busy continuous from cycle 1 to 27.
- ctrl_MULT and ctrl_DIV asserted together -> op_is_div=0 and RDY at +18. Separately, reset asserted mid-RUN at count=7 -> all outputs 0 next cycle and no RDY.
- With MULTDIV_EARLY_TERM_EN, early_done=1 at count=4 of a multiply -> DONE the next cycle (RDY in cycle 7). The same stimulus on a divide has no effect (RDY in cycle 34).
